// File: rtl/sm_dmem_responder.sv
// Data-memory responder: req/ready word access with programmable wait states,
// registered read data and an async debug byte port. Option: SM_DMEM_BYTE_WRITE_EN.
module sm_dmem_responder #(
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_STATES = 1,
  parameter int DBG_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic                 we,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
`ifdef SM_DMEM_BYTE_WRITE_EN
  input  logic [3:0]           be,
`endif
  output logic                 ready,
  output logic [31:0]          rdata,
  output logic                 err,
  output logic                 busy,
  input  logic [DBG_WIDTH-1:0] dbgAddr,
  output logic [7:0]           dbgData
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    to_resp;
  logic                    mem_we;
  logic [31:0]             mem_wdata;
  logic [31:0]             dbg_ext;
  logic [31:0]             mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    to_resp = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          idx_d   = addr[ADDR_WIDTH-1:0];
          err_d   = (addr >> ADDR_WIDTH) != '0;
          wdata_d = wdata;
`ifdef SM_DMEM_BYTE_WRITE_EN
          be_d    = be;
`else
          be_d    = '1;
`endif
          cnt_d   = 4'(WAIT_STATES);
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_RESP;
            to_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          to_resp = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        mem_we  = we_q && !err_q;
      end
      default: state_d = S_IDLE;
    endcase
    // Read data uses the _d copies so the zero-wait path (IDLE->RESP) sees this request.
    if (to_resp && !we_d) begin
      rdata_d = err_d ? '0 : mem_q[idx_d];
    end
  end

  always_comb begin
    mem_wdata = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      mem_wdata[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_q[idx_q][8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= mem_wdata;
    end
  end

  always_comb begin
    dbg_ext = 32'(dbgAddr);
    dbgData = (dbg_ext < 32'(DEPTH)) ? mem_q[dbg_ext[ADDR_WIDTH-1:0]][7:0] : '0;
  end

  assign ready = (state_q == S_RESP);
  assign err   = (state_q == S_RESP) && err_q;
  assign busy  = (state_q != S_IDLE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_sm_dmem_responder.sv
// Self-checking bench for sm_dmem_responder: three instances (WAIT_STATES 1, 2, 0),
// directed table, hand-written corner sequences and randomized traffic vs a memory model.
module tb_sm_dmem_responder;

  localparam int N   = 3;
  localparam int WS0 = 1;
  localparam int WS1 = 2;
  localparam int WS2 = 0;

  logic        clk = 1'b0;
  logic        rst_n    [N];
  logic        req      [N];
  logic        we       [N];
  logic [31:0] addr     [N];
  logic [31:0] wdata    [N];
  logic [3:0]  be       [N];
  logic        ready    [N];
  logic [31:0] rdata    [N];
  logic        err      [N];
  logic        busy     [N];
  logic [7:0]  dbg_addr [N];
  logic [7:0]  dbg_data [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int DW = (g == 1) ? 7 : 4;
    sm_dmem_responder #(
      .ADDR_WIDTH (6),
      .WAIT_STATES((g == 0) ? WS0 : (g == 1) ? WS1 : WS2),
      .DBG_WIDTH  (DW)
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n[g]),
      .req    (req[g]),
      .we     (we[g]),
      .addr   (addr[g]),
      .wdata  (wdata[g]),
`ifdef SM_DMEM_BYTE_WRITE_EN
      .be     (be[g]),
`endif
      .ready  (ready[g]),
      .rdata  (rdata[g]),
      .err    (err[g]),
      .busy   (busy[g]),
      .dbgAddr(dbg_addr[g][DW-1:0]),
      .dbgData(dbg_data[g])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: word array per instance plus the last read response.
  logic [31:0] model_mem [N][64];
  bit          model_vld [N][64];
  logic [31:0] last_rd   [N];
  logic [7:0]  dbg_at_ready, dbg_after;

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t tab [10];

  function automatic int ws_of(input int i);
    return (i == 0) ? WS0 : (i == 1) ? WS1 : WS2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_txn(input int i, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b,
                           output logic [31:0] exp_rd, output bit exp_err);
    bit inr;
    inr     = (a < 64);
    exp_err = !inr;
    if (w) begin
      if (inr) begin
`ifdef SM_DMEM_BYTE_WRITE_EN
        for (int l = 0; l < 4; l++)
          if (b[l]) model_mem[i][a][8*l +: 8] = d[8*l +: 8];
        if (b == 4'hF) model_vld[i][a] = 1'b1;
`else
        model_mem[i][a] = d;
        model_vld[i][a] = 1'b1;
`endif
      end
      exp_rd = last_rd[i];
    end else begin
      exp_rd     = inr ? model_mem[i][a] : 32'h0;
      last_rd[i] = exp_rd;
    end
  endtask

  task automatic do_txn(input int i, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rd, output bit e);
    int lat;
    lat = 0;
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
    @(posedge clk);
    #1 req[i] = 1'b0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) chk("busy_in_flight", 32'(busy[i]), 32'd1);
      if (ready[i]) lat = k;
    end
    chk("latency", 32'(lat), 32'(ws_of(i) + 1));
    rd = rdata[i];
    e  = err[i];
    dbg_at_ready = dbg_data[i];
    @(negedge clk);
    dbg_after = dbg_data[i];
    chk("ready_one_cycle", 32'(ready[i]), 32'd0);
    chk("err_outside_resp", 32'(err[i]), 32'd0);
    chk("rdata_held", rdata[i], rd);
  endtask

  task automatic txn_model(input int i, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b);
    logic [31:0] exp_rd, act_rd;
    bit exp_err, act_err;
    model_txn(i, w, a, d, b, exp_rd, exp_err);
    do_txn(i, w, a, d, b, act_rd, act_err);
    chk("model_err", 32'(act_err), 32'(exp_err));
    chk("model_rdata", act_rd, exp_rd);
  endtask

  task automatic txn_const(input string name, input int i, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b,
                           input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] m_rd, act_rd;
    bit m_err, act_err;
    model_txn(i, w, a, d, b, m_rd, m_err);
    do_txn(i, w, a, d, b, act_rd, act_err);
    chk({name, "_err"}, 32'(act_err), 32'(exp_err));
    chk({name, "_rdata"}, act_rd, exp_rd);
  endtask

  task automatic b2b(input int i, input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] a2);
    logic [31:0] as [3];
    int n, last, c0;
    as[0] = a0; as[1] = a1; as[2] = a2;
    n = 0; last = 0;
    @(negedge clk);
    req[i] = 1'b1; we[i] = 1'b0; addr[i] = as[0];
    c0 = cyc;
    for (int k = 0; k < 60 && n < 3; k++) begin
      @(negedge clk);
      if (ready[i]) begin
        chk("b2b_rdata", rdata[i], model_mem[i][as[n]]);
        if (n == 0) chk("b2b_first_latency", 32'(cyc - c0), 32'(ws_of(i) + 1));
        else        chk("b2b_spacing", 32'(cyc - last), 32'(ws_of(i) + 2));
        last = cyc;
        n++;
        if (n < 3) addr[i] = as[n];
        else       req[i] = 1'b0;
      end
    end
    req[i] = 1'b0;
    chk("b2b_count", 32'(n), 32'd3);
    last_rd[i] = model_mem[i][as[2]];
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  b;
    bit          w;
    int          r;

    tab[0] = '{1'b1, 32'd3,          32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tab[1] = '{1'b0, 32'd3,          32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    tab[2] = '{1'b1, 32'd0,          32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0};
    tab[3] = '{1'b1, 32'h40,         32'hFFFFFFFF, 4'hF, 32'hDEADBEEF, 1'b1};
    tab[4] = '{1'b0, 32'd0,          32'h0,        4'hF, 32'h11223344, 1'b0};
    tab[5] = '{1'b0, 32'h40,         32'h0,        4'hF, 32'h0,        1'b1};
    tab[6] = '{1'b1, 32'd63,         32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    tab[7] = '{1'b0, 32'd63,         32'h0,        4'hF, 32'hCAFEF00D, 1'b0};
    tab[8] = '{1'b0, 32'h80000000,   32'h0,        4'hF, 32'h0,        1'b1};
    tab[9] = '{1'b0, 32'd3,          32'h0,        4'hF, 32'hDEADBEEF, 1'b0};

    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0;
      wdata[i] = '0; be[i] = 4'hF; dbg_addr[i] = '0; last_rd[i] = '0;
      for (int j = 0; j < 64; j++) model_vld[i][j] = 1'b0;
    end

    #3;
    for (int i = 0; i < N; i++) begin
      chk("reset_ready", 32'(ready[i]), 32'd0);
      chk("reset_busy",  32'(busy[i]),  32'd0);
      chk("reset_err",   32'(err[i]),   32'd0);
      chk("reset_rdata", rdata[i],      32'd0);
    end
    #9;
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;

    // Directed table on the WAIT_STATES=1 instance.
    for (int t = 0; t < 10; t++)
      txn_const($sformatf("tab%0d", t), 0, tab[t].w, tab[t].a, tab[t].d, tab[t].b,
                tab[t].exp_rd, tab[t].exp_err);
    dbg_addr[0] = 8'd3;
    #1 chk("dbg_addr3", 32'(dbg_data[0]), 32'hEF);

    // Debug port shows the old byte during the write response, new byte after commit.
    dbg_addr[0] = 8'd5;
    txn_model(0, 1'b1, 32'd5, 32'h12345655, 4'hF);
    txn_model(0, 1'b1, 32'd5, 32'h123456AA, 4'hF);
    chk("dbg_old_at_resp", 32'(dbg_at_ready), 32'h55);
    chk("dbg_new_after",   32'(dbg_after),    32'hAA);

    // Reset during WAIT of a write drops it.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd5; wdata[0] = 32'hBAD0BAD0; be[0] = 4'hF;
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    chk("busy_before_reset", 32'(busy[0]), 32'd1);
    rst_n[0] = 1'b0;
    #1;
    chk("busy_after_reset",  32'(busy[0]),  32'd0);
    chk("ready_after_reset", 32'(ready[0]), 32'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    last_rd[0] = '0;
    r = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ready[0]) r++;
    end
    chk("no_ready_after_reset", 32'(r), 32'd0);
    txn_const("reset_readback", 0, 1'b0, 32'd5, 32'h0, 4'hF, 32'h123456AA, 1'b0);

`ifdef SM_DMEM_BYTE_WRITE_EN
    txn_model(0, 1'b1, 32'd7, 32'hDEADBEEF, 4'hF);
    txn_model(0, 1'b1, 32'd7, 32'h0000AB00, 4'b0010);
    txn_const("be_lane1", 0, 1'b0, 32'd7, 32'h0, 4'hF, 32'hDEADABEF, 1'b0);
    txn_model(0, 1'b1, 32'd7, 32'h12345678, 4'b0000);
    txn_const("be_none", 0, 1'b0, 32'd7, 32'h0, 4'hF, 32'hDEADABEF, 1'b0);
`endif

    // Debug beyond depth on the 7-bit debug instance.
    txn_model(1, 1'b1, 32'd2, 32'h000000C3, 4'hF);
    dbg_addr[1] = 8'd2;
    #1 chk("dbg_in_range", 32'(dbg_data[1]), 32'hC3);
    dbg_addr[1] = 8'd64;
    #1 chk("dbg_beyond_depth", 32'(dbg_data[1]), 32'h00);

    // Back-to-back reads with req held high on every instance.
    for (int i = 0; i < N; i++) begin
      txn_model(i, 1'b1, 32'd10, 32'hA0A0_0010 + 32'(i), 4'hF);
      txn_model(i, 1'b1, 32'd11, 32'hB1B1_0011 + 32'(i), 4'hF);
      txn_model(i, 1'b1, 32'd12, 32'hC2C2_0012 + 32'(i), 4'hF);
      b2b(i, 32'd10, 32'd11, 32'd12);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < N; i++) begin
      for (int t = 0; t < 40; t++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      a = 32'h40 + 32'($urandom_range(0, 1000));
        else if (r == 1) a = 32'h1 << $urandom_range(6, 31);
        else             a = 32'($urandom_range(0, 63));
        w = 1'($urandom_range(0, 1));
        if (!w && a < 64 && !model_vld[i][a]) w = 1'b1;
        d = $urandom;
`ifdef SM_DMEM_BYTE_WRITE_EN
        b = 4'($urandom_range(0, 15));
        if (a < 64 && !model_vld[i][a]) b = 4'hF;
`else
        b = 4'hF;
`endif
        txn_model(i, w, a, d, b);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
